// File: rtl/spi_reg_bank.sv
// Configuration register bank fed by strobed address/data bytes from the SPI front end.
// Writes auto-increment the pointer; the byte at the pointer is shifted out MSB-first on poci.
module spi_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         addr_valid,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic                         data_valid,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         txn_end,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [ADDR_W-1:0]            cur_addr,
  output logic                         busy,
  output logic                         addr_err,
  output logic                         poci
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] LP_NUM = NUM_REGS[ADDR_W:0];

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] r_cur_addr;
  logic [DATA_W-1:0] r_shreg;
  logic              r_addr_err;

  logic [ADDR_W-1:0] w_next_addr;
  logic              w_new_ok;
  logic              w_cur_ok;
  logic              w_next_ok;
  logic [DATA_W-1:0] w_rd_new;
  logic [DATA_W-1:0] w_rd_next;
  logic              w_data_acc;
  logic              w_we;

  assign w_next_addr = r_cur_addr + 1'b1;
  assign w_new_ok    = {1'b0, addr_in}     < LP_NUM;
  assign w_cur_ok    = {1'b0, r_cur_addr}  < LP_NUM;
  assign w_next_ok   = {1'b0, w_next_addr} < LP_NUM;

  // Readback sources see pre-edge contents; out-of-range addresses read as zero.
  assign w_rd_new  = w_new_ok  ? r_regs[addr_in[IDX_W-1:0]]     : '0;
  assign w_rd_next = w_next_ok ? r_regs[w_next_addr[IDX_W-1:0]] : '0;

  // addr_valid takes priority over a simultaneous data byte.
  assign w_data_acc = (r_state == ST_ACTIVE) && !addr_valid && data_valid;
  assign w_we       = w_data_acc && w_cur_ok;

  always_ff @(posedge sclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (addr_valid)
      w_state_next = ST_ACTIVE;
    else if (r_state == ST_ACTIVE && txn_end)
      w_state_next = ST_IDLE;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[r_cur_addr[IDX_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_cur_addr <= '0;
      r_shreg    <= '0;
      r_addr_err <= 1'b0;
    end else if (addr_valid) begin
      r_cur_addr <= addr_in;
      r_addr_err <= 1'b0;
      r_shreg    <= w_rd_new;
    end else if (r_state == ST_ACTIVE) begin
      if (data_valid) begin
        if (!w_cur_ok) r_addr_err <= 1'b1;
        r_cur_addr <= w_next_addr;
        r_shreg    <= txn_end ? '0 : w_rd_next;
      end else if (txn_end) begin
        r_shreg <= '0;
      end else begin
        r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
      end
    end else begin
      r_shreg <= '0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

  assign cur_addr = r_cur_addr;
  assign busy     = (r_state == ST_ACTIVE);
  assign addr_err = r_addr_err;
  assign poci     = r_shreg[DATA_W-1];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: transaction-level model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_spi_reg_bank;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         addr_valid = 1'b0;
  logic [7:0]   addr_in = '0;
  logic         data_valid = 1'b0;
  logic [7:0]   data_in = '0;
  logic         txn_end = 1'b0;
  logic [127:0] regs_flat;
  logic [7:0]   cur_addr;
  logic         busy;
  logic         addr_err;
  logic         poci;

  int total = 0;
  int bad = 0;

  spi_reg_bank #(.NUM_REGS(16), .DATA_W(8), .ADDR_W(8)) dut (
    .sclk(sclk), .rst(rst),
    .addr_valid(addr_valid), .addr_in(addr_in),
    .data_valid(data_valid), .data_in(data_in),
    .txn_end(txn_end),
    .regs_flat(regs_flat), .cur_addr(cur_addr),
    .busy(busy), .addr_err(addr_err), .poci(poci)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: register contents, pointer, error flag,
  // and the readback byte plus how many bits of it have already left.
  logic [7:0] m_regs [16];
  int         m_cur = 0;
  bit         m_err = 0;
  bit         m_act = 0;
  logic [7:0] m_rb = '0;
  int         m_sent = 8;
  bit         m_ok = 0;

  function automatic logic [7:0] m_read(input int a);
    return (a < 16) ? m_regs[a] : 8'h00;
  endfunction

  initial begin
    logic s_rst, s_av, s_dv, s_te;
    logic [7:0] s_ai, s_di;
    logic [127:0] e_flat;
    int nxt;
    forever begin
      @(posedge sclk);
      s_rst = rst; s_av = addr_valid; s_ai = addr_in;
      s_dv = data_valid; s_di = data_in; s_te = txn_end;
      if (s_rst) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_cur = 0; m_err = 0; m_act = 0; m_rb = 8'h00; m_sent = 8; m_ok = 1;
      end else if (m_ok) begin
        if (s_av) begin
          m_act = 1; m_cur = s_ai; m_err = 0;
          m_rb = m_read(s_ai); m_sent = 0;
        end else if (m_act) begin
          if (s_dv) begin
            nxt = (m_cur + 1) % 256;
            m_rb = m_read(nxt);
            if (m_cur < 16) m_regs[m_cur] = s_di;
            else m_err = 1;
            m_cur = nxt;
            m_sent = 0;
          end else if (m_sent < 8) begin
            m_sent++;
          end
          if (s_te) begin
            m_act = 0; m_rb = 8'h00;
          end
        end
      end
      @(negedge sclk);
      if (m_ok) begin
        for (int i = 0; i < 16; i++) e_flat[i*8 +: 8] = m_regs[i];
        chk("cyc_regs_flat", regs_flat, e_flat);
        chk("cyc_cur_addr", {120'd0, cur_addr}, 128'(m_cur));
        chk("cyc_busy", {127'd0, busy}, {127'd0, m_act});
        chk("cyc_addr_err", {127'd0, addr_err}, {127'd0, m_err});
        chk("cyc_poci", {127'd0, poci}, {127'd0, (m_sent < 8) ? m_rb[7 - m_sent] : 1'b0});
      end
    end
  end

  task automatic drive(input bit r, input bit av, input logic [7:0] ai,
                       input bit dv, input logic [7:0] di, input bit te);
    rst = r; addr_valid = av; addr_in = ai;
    data_valid = dv; data_in = di; txn_end = te;
    @(posedge sclk);
    #1;
    rst = 0; addr_valid = 0; data_valid = 0; txn_end = 0;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic addr(input logic [7:0] a);
    drive(0, 1, a, 0, 8'h00, 0);
  endtask

  task automatic wr(input logic [7:0] d);
    drive(0, 0, 8'h00, 1, d, 0);
  endtask

  task automatic fin();
    drive(0, 0, 8'h00, 0, 8'h00, 1);
  endtask

  initial begin
    logic [127:0] exp_flat;
    logic [7:0]   bits;

    drive(1, 0, 8'h00, 0, 8'h00, 0);
    idle();

    // Reset after traffic
    addr(8'd9); wr(8'h5A); wr(8'h6B);
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    drive(1, 1, 8'h04, 1, 8'h33, 0);
    chk("rst_regs", regs_flat, 128'd0);
    chk("rst_cur", {120'd0, cur_addr}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, addr_err}, 128'd0);
    chk("rst_poci", {127'd0, poci}, 128'd0);
    $display("txn reset_after_traffic done");

    // Burst write at 3
    addr(8'd3); wr(8'hA5); wr(8'h3C); wr(8'hFF); fin();
    exp_flat = '0;
    exp_flat[3*8 +: 8] = 8'hA5;
    exp_flat[4*8 +: 8] = 8'h3C;
    exp_flat[5*8 +: 8] = 8'hFF;
    chk("burst_regs", regs_flat, exp_flat);
    chk("burst_cur", {120'd0, cur_addr}, 128'd6);
    chk("burst_busy", {127'd0, busy}, 128'd0);
    chk("burst_err", {127'd0, addr_err}, 128'd0);
    $display("txn burst_write addr=3 done");

    // Readback of reg7 = 0x96
    addr(8'd7); wr(8'h96); fin();
    addr(8'd7);
    bits = 8'h96;
    chk("rb_bit1", {127'd0, poci}, {127'd0, bits[7]});
    for (int k = 1; k < 8; k++) begin
      idle();
      chk($sformatf("rb_bit%0d", k + 1), {127'd0, poci}, {127'd0, bits[7 - k]});
    end
    idle();
    chk("rb_after", {127'd0, poci}, 128'd0);
    fin();
    $display("txn readback addr=7 done");

    // Out of range and wrap
    addr(8'd14); wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    chk("oor_reg14", {120'd0, regs_flat[14*8 +: 8]}, 128'h11);
    chk("oor_reg15", {120'd0, regs_flat[15*8 +: 8]}, 128'h22);
    chk("oor_err", {127'd0, addr_err}, 128'd1);
    chk("oor_cur", {120'd0, cur_addr}, 128'd18);
    addr(8'd255); wr(8'h99);
    chk("wrap_cur", {120'd0, cur_addr}, 128'd0);
    chk("wrap_err", {127'd0, addr_err}, 128'd1);
    chk("wrap_reg0", {120'd0, regs_flat[7:0]}, 128'd0);
    fin();
    $display("txn out_of_range_and_wrap done");

    // Collisions
    addr(8'd0);
    drive(0, 1, 8'd2, 1, 8'h55, 0);
    chk("col_av_reg0", {120'd0, regs_flat[0*8 +: 8]}, 128'd0);
    chk("col_av_reg2", {120'd0, regs_flat[2*8 +: 8]}, 128'd0);
    chk("col_av_cur", {120'd0, cur_addr}, 128'd2);
    drive(0, 0, 8'h00, 1, 8'h77, 1);
    chk("col_te_reg2", {120'd0, regs_flat[2*8 +: 8]}, 128'h77);
    chk("col_te_busy", {127'd0, busy}, 128'd0);
    chk("col_te_cur", {120'd0, cur_addr}, 128'd3);
    wr(8'h88);
    chk("col_idle_cur", {120'd0, cur_addr}, 128'd3);
    chk("col_idle_reg3", {120'd0, regs_flat[3*8 +: 8]}, 128'hA5);
    $display("txn collisions done");

    // Reset mid-burst
    addr(8'd0); wr(8'h01);
    chk("mid_reg0_pre", {120'd0, regs_flat[7:0]}, 128'h01);
    drive(1, 0, 8'h00, 1, 8'h02, 0);
    chk("mid_reg0", {120'd0, regs_flat[7:0]}, 128'd0);
    chk("mid_reg1", {120'd0, regs_flat[15:8]}, 128'd0);
    chk("mid_busy", {127'd0, busy}, 128'd0);
    chk("mid_cur", {120'd0, cur_addr}, 128'd0);
    $display("txn reset_mid_burst done");

    idle(); idle();
    @(posedge sclk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
